// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port WORD x 2^ADDR memory macro between an instruction-fetch read
//   port (I) and a load/store port (D). At most one request is granted per cycle. The
//   granted command drives mem_a/mem_w/mem_d, and read data is steered back one cycle
//   later to the port that issued the read.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin on contention (1-bit pointer, D wins first after reset)
//     undefined -> fixed priority D > I, with a starvation counter that forces I through
//                  once STARVE_MAX consecutive I denials have accumulated
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_req, i_addr / i_gnt            fetch read request / combinational accept
//   i_rvalid, i_rdata                fetch read return (valid one cycle after grant)
//   d_req, d_we, d_addr, d_wdata     load/store request
//   d_gnt                            combinational accept
//   d_rvalid, d_rdata                load read return (never for writes)
//   mem_a, mem_w, mem_d, mem_q       memory macro command pins and read data
module mem_port_arbiter #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned ADDR       = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [ADDR-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [WORD-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [ADDR-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [WORD-1:0] d_rdata,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  logic            run_q;
  owner_e          owner_q;
  logic [ADDR-1:0] last_a_q;
  logic [WORD-1:0] last_d_q;
  logic            contended;
  logic            i_wins_contention;

  assign contended = run_q & i_req & d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether I won the last contended cycle; reset value 1 lets D go first.
  logic rr_last_i_q;

  assign i_wins_contention = ~rr_last_i_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_i_q <= 1'b1;
    end else if (contended) begin
      rr_last_i_q <= i_gnt;
    end
  end
`else
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q;

  assign i_wins_contention = (starve_q == CntMax);

  // Counts consecutive cycles I is kept waiting; saturates so it can force exactly one grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!i_req || i_gnt) begin
      starve_q <= '0;
    end else if (starve_q != CntMax) begin
      starve_q <= starve_q + CntW'(1);
    end
  end
`endif

  // Single winner per cycle; nothing is granted until run is set after reset.
  assign i_gnt = run_q & i_req & (~d_req | i_wins_contention);
  assign d_gnt = run_q & d_req & (~i_req | ~i_wins_contention);

  // Idle cycles keep the address/data pins at their last values to avoid toggling.
  always_comb begin
    mem_a = last_a_q;
    mem_d = last_d_q;
    mem_w = 1'b0;
    if (d_gnt) begin
      mem_a = d_addr;
      mem_d = d_wdata;
      mem_w = d_we;
    end else if (i_gnt) begin
      mem_a = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      owner_q  <= OwnNone;
      last_a_q <= '0;
      last_d_q <= '0;
    end else begin
      run_q    <= 1'b1;
      last_a_q <= mem_a;
      last_d_q <= mem_d;
      if (i_gnt) begin
        owner_q <= OwnI;
      end else if (d_gnt && !d_we) begin
        owner_q <= OwnD;
      end else begin
        owner_q <= OwnNone;
      end
    end
  end

  assign i_rvalid = (owner_q == OwnI);
  assign d_rvalid = (owner_q == OwnD);
  assign i_rdata  = mem_q;
  assign d_rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives directed scenarios into mem_port_arbiter with a behavioural memory macro attached.
//   A spec-level model (grant rules, reference memory image, expected read data) is checked
//   against the DUT every cycle, and literal expectations pin the key scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned WORD = 32;
  localparam int unsigned ADDR = 16;
  localparam int unsigned SM   = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_req, d_req, d_we;
  logic [ADDR-1:0] i_addr, d_addr;
  logic [WORD-1:0] d_wdata;
  logic            i_gnt, d_gnt, i_rvalid, d_rvalid, mem_w;
  logic [WORD-1:0] i_rdata, d_rdata, mem_d;
  logic [ADDR-1:0] mem_a;
  logic [WORD-1:0] mem_q;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.WORD(WORD), .ADDR(ADDR), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory macro: one access per clock, Q updates the cycle after a read, writes leave Q.
  logic [WORD-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_w) mem[mem_a] <= mem_d;
    else       mem_q <= mem[mem_a];
  end

  // ---------------- behavioural model ----------------
  logic [WORD-1:0] ref_mem [0:65535];
  bit              m_run = 0;
  int              m_starve = 0;
  bit              m_rr_last_i = 1;
  int              m_owner = 0;          // 0 none, 1 I, 2 D
  logic [WORD-1:0] m_rdata = '0;
  logic [ADDR-1:0] m_last_a = '0;
  logic [WORD-1:0] m_last_d = '0;

  function automatic void model_grants(output bit ig, output bit dg);
    bit i_first;
    ig = 0;
    dg = 0;
    if (m_run) begin
`ifdef ARB_ROUND_ROBIN_EN
      i_first = !m_rr_last_i;
`else
      i_first = (m_starve == int'(SM));
`endif
      if (i_req && !d_req)      ig = 1;
      else if (d_req && !i_req) dg = 1;
      else if (i_req && d_req) begin
        ig = i_first;
        dg = !i_first;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit ig, dg;
    if (!rst_n) begin
      m_run = 0; m_starve = 0; m_rr_last_i = 1; m_owner = 0;
      m_last_a = '0; m_last_d = '0;
    end else begin
      model_grants(ig, dg);
      if (dg && d_we) ref_mem[d_addr] = d_wdata;
      m_owner = ig ? 1 : (dg && !d_we) ? 2 : 0;
      if (ig) m_rdata = ref_mem[i_addr];
      else if (dg && !d_we) m_rdata = ref_mem[d_addr];
      if (dg) begin
        m_last_a = d_addr;
        m_last_d = d_wdata;
      end else if (ig) begin
        m_last_a = i_addr;
      end
      if (!i_req || ig) m_starve = 0;
      else if (m_starve < int'(SM)) m_starve++;
      if (m_run && i_req && d_req) m_rr_last_i = ig;
      m_run = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ig, dg;
    logic [ADDR-1:0] ea;
    model_grants(ig, dg);
    ea = dg ? d_addr : ig ? i_addr : m_last_a;
    chk("i_gnt", {31'b0, i_gnt}, {31'b0, ig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, dg});
    chk("mem_w", {31'b0, mem_w}, {31'b0, dg && d_we});
    chk("mem_a", {16'b0, mem_a}, {16'b0, ea});
    if (dg)       chk("mem_d", mem_d, d_wdata);
    else if (!ig) chk("mem_d_hold", mem_d, m_last_d);
    chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, m_owner == 1});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_owner == 2});
    if (m_owner == 1) chk("i_rdata", i_rdata, m_rdata);
    if (m_owner == 2) chk("d_rdata", d_rdata, m_rdata);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] dseq, iseq, d_exp, i_exp;
    int          i_hits;
    rst_n = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 65536; k++) begin
      mem[k] = '0;
      ref_mem[k] = '0;
    end
    mem[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0100] = 32'h11111111; ref_mem[16'h0100] = 32'h11111111;
    mem[16'h0200] = 32'h22222222; ref_mem[16'h0200] = 32'h22222222;

    // Reset state
    mid_cycle();
    chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
    chk("rst_mem_a", {16'b0, mem_a}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    mid_cycle();              // run still clear in this cycle
    i_req = 1; i_addr = 16'h0010;
    #1 chk("run0_i_gnt", {31'b0, i_gnt}, 32'd0);
    i_req = 0;
    next_cycle();

    // 1. I-only read
    i_req = 1; i_addr = 16'h0010;
    mid_cycle();
    chk("t1_i_gnt", {31'b0, i_gnt}, 32'd1);
    chk("t1_mem_a", {16'b0, mem_a}, 32'h0010);
    next_cycle();
    i_req = 0;
    mid_cycle();
    chk("t1_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    next_cycle();

    // 2. D write then read-after-write
    d_req = 1; d_we = 1; d_addr = 16'h1234; d_wdata = 32'hA5A5A5A5;
    mid_cycle();
    chk("t2_mem_w_wr", {31'b0, mem_w}, 32'd1);
    chk("t2_mem_d", mem_d, 32'hA5A5A5A5);
    next_cycle();
    d_we = 0;
    mid_cycle();
    chk("t2_mem_w_rd", {31'b0, mem_w}, 32'd0);
    chk("t2_no_rvalid_for_write", {31'b0, d_rvalid}, 32'd0);
    next_cycle();
    d_req = 0;
    mid_cycle();
    chk("t2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'hA5A5A5A5);
    next_cycle();

    // 3/4. Both ports reading continuously for 12 cycles
    i_req = 1; i_addr = 16'h0100;
    d_req = 1; d_we = 0; d_addr = 16'h0200;
    for (int k = 0; k < 12; k++) begin
      mid_cycle();
      dseq[k] = d_gnt;
      iseq[k] = i_gnt;
      next_cycle();
    end
`ifdef ARB_ROUND_ROBIN_EN
    d_exp = 12'h555;
    i_exp = 12'hAAA;
`else
    d_exp = 12'hEFF;
    i_exp = 12'h100;
`endif
    chk("t3_d_gnt_seq", {20'b0, dseq}, {20'b0, d_exp});
    chk("t3_i_gnt_seq", {20'b0, iseq}, {20'b0, i_exp});
    i_req = 0;
    d_req = 0;
    mid_cycle();
    chk("t3_last_rvalid_d", {31'b0, d_rvalid}, {31'b0, d_exp[11]});
    next_cycle();

    // 6. I request withdrawn while D holds the bus
    i_hits = 0;
    d_req = 1; d_we = 0; d_addr = 16'h0200;
    i_req = 1; i_addr = 16'h0300;
    mid_cycle();
    chk("t6_i_gnt", {31'b0, i_gnt}, 32'd0);
    next_cycle();
    i_req = 0;
    for (int k = 0; k < 3; k++) begin
      mid_cycle();
      if (i_rvalid || i_gnt || mem_a == 16'h0300) i_hits++;
      next_cycle();
    end
    d_req = 0;
    chk("t6_no_i_activity", i_hits, 32'd0);

    // 5. Reset arriving after a read grant but before its edge
    i_req = 1; i_addr = 16'h0010;
    mid_cycle();
    chk("t5_i_gnt_pre", {31'b0, i_gnt}, 32'd1);
    #2 rst_n = 1'b0;
    d_req = 1; d_we = 1; d_addr = 16'h0400; d_wdata = 32'h5A5A5A5A;
    #1;
    chk("t5_rst_i_gnt", {31'b0, i_gnt}, 32'd0);
    chk("t5_rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("t5_rst_mem_w", {31'b0, mem_w}, 32'd0);
    next_cycle();
    chk("t5_rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    rst_n = 1'b1;
    mid_cycle();
    chk("t5_run0_i_gnt", {31'b0, i_gnt}, 32'd0);
    chk("t5_run0_mem_w", {31'b0, mem_w}, 32'd0);
    chk("t5_run0_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    next_cycle();
    chk("t5_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t5_mem_w", {31'b0, mem_w}, 32'd1);
    next_cycle();
    d_req = 0;
    #1 chk("t5_i_gnt_retry", {31'b0, i_gnt}, 32'd1);
    next_cycle();
    i_req = 0;
    mid_cycle();
    chk("t5_i_rdata", i_rdata, 32'hDEADBEEF);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
